seg7_scan_ctrl: RTL and testbench
=================================

# seg7_scan_ctrl

Parametrised, time-multiplexed seven-segment display controller for N-digit common-anode displays, with active-low segments and anodes. Adds the following over a fixed 4-digit hex driver:
- configurable digit count and scan rate;
- double-buffered, tear-free data loading;
- per-digit decimal point and blanking;
- leading-zero suppression;
- 16-level PWM brightness.

It sits between any status/debug source and the board-level SEG/AN pins.

## Interface
- NUM_DIGITS, 8, number of scanned digits, 1..8
- DIV_WIDTH, 17, slot counter width; each digit is driven for 2^DIV_WIDTH clocks (≈763 Hz per slot at 100 MHz); minimum 4
- clk  in  1  system clock (`clk`)
- reset  in  1  reset (`reset`): asynchronous, active-high
- load  in  1  single-cycle strobe; captures data_in, dp_in, blank_in into the shadow registers
- data_in  in  4*NUM_DIGITS  hex nibbles; nibble i drives digit i (digit 0 is rightmost)
- dp_in  in  NUM_DIGITS  decimal point per digit, 1 = lit
- blank_in  in  NUM_DIGITS  per-digit forced blank, 1 = dark
- lzs_en  in  1  leading-zero suppression enable, sampled live
- brightness  in  4  PWM duty; 15 = full on, 0 = 1/16 duty
- SEG  out  8  {dp,g,f,e,d,c,b,a}, active low
- AN  out  NUM_DIGITS  anodes, active low, one-hot-low when lit
- pending  out  1  shadow holds data not yet displayed
- frame_tick  out  1  one-cycle pulse at each frame boundary

## Operation
- slot_cnt (DIV_WIDTH bits) increments every clock and wraps.
- slot_end = (slot_cnt == all ones).
- On slot_end, digit_idx advances by one; it wraps from NUM_DIGITS-1 to 0.
- The frame boundary is slot_end with digit_idx == NUM_DIGITS-1. At the boundary:
  - frame_tick = 1 for that cycle;
  - if pending, active registers <= shadow and pending <= 0.
- On load, shadow <= inputs and pending <= 1. A load while pending overwrites the shadow; the latest load wins.
- load on the boundary cycle:
  - the old shadow moves to active;
  - the new inputs go to the shadow;
  - pending stays 1.
- Leading-zero suppression applies when lzs_en = 1. Digit i > 0 is dark iff nibble j == 0 and dp j == 0 for every j >= i. Digit 0 is never suppressed.
- A digit is dark if blank_in (active copy) is set or the digit is suppressed. A dark digit drives AN all ones and SEG 8'hFF.
- PWM: pwm_on = (slot_cnt[DIV_WIDTH-1 -: 4] <= brightness). When pwm_on = 0, AN is all ones.
- Hex glyphs use the standard table (A, b, C, d, E, F). SEG[7] = ~dp.

## Timing
- Reset values: SEG = 8'hFF, AN = all ones, pending = 0, frame_tick = 0, slot_cnt = 0, digit_idx = 0. Active and shadow registers reset to 0, with blank set to all ones, so the display is dark until the first load takes effect.
- SEG and AN are registered and reflect digit_idx and slot_cnt with 1-cycle latency. SEG and AN always change in the same cycle.
- Load-to-display latency is at most NUM_DIGITS·2^DIV_WIDTH + 1 clocks. Data is never mixed within a frame.
- brightness and lzs_en take effect within 1 cycle. There is no glitch beyond the registered output.
- Reset asserted mid-frame forces all outputs to their reset values asynchronously and discards the shadow.

## Structure
- Package seg7_pkg holds:
  - the 16-entry hex-to-segment constant table;
  - SEG_OFF = 8'hFF;
  - the DP bit index constant.
- Sub-module seg7_hex_decoder (combinational nibble → 7-bit glyph) is instantiated once on the muxed nibble.
- Top level contains:
  - slot counter and digit index;
  - shadow/active registers and pending;
  - suppression mask logic;
  - PWM compare;
  - output registers.

## Test plan
All scenarios use the bench configuration NUM_DIGITS = 4, DIV_WIDTH = 4 (16 clocks per slot).
- Reset, then load data_in = 16'h12AF, blank_in = 0, brightness = 15 → after the first boundary, AN cycles 1110, 1101, 1011, 0111 every 16 clocks. SEG is F = 8'h8E, A = 8'h88, 2 = 8'hA4, 1 = 8'hF9.
- lzs_en = 1, data 16'h0005, dp_in = 0 → digits 3..1 dark, digit 0 shows 8'h92. Then dp_in = 4'b0100 → digit 3 dark; digit 2 shows 8'h40 (0 with dp); digit 1 shows 0.
- Load 16'h1111 mid-frame, then 16'h2222 before the boundary → pending = 1 until the boundary; the next frame shows only 2s; no frame ever mixes values.
- load on the boundary cycle → frame_tick = 1, the previously shadowed data displays, and pending stays 1 into the next frame.
- brightness = 3 → each anode is low for exactly 4 of its 16 slot clocks (slot_cnt 0..3). brightness = 15 → low for 16 of 16.
- Assert reset mid-slot asynchronously → SEG = 8'hFF, AN = 4'hF and pending = 0 immediately; the display stays dark after release until a new load plus one boundary.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment scan controller.
// Segment order is {dp,g,f,e,d,c,b,a}, active low.
package seg7_pkg;

    localparam logic [6:0] HEX_TABLE [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30,
        7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03,
        7'h46, 7'h21, 7'h06, 7'h0E
    };

    localparam logic [7:0] SEG_OFF = 8'hFF;
    localparam int         DP_BIT  = 7;

endpackage

// File: rtl/seg7_hex_decoder.sv
// Nibble to active-low {g,f,e,d,c,b,a} glyph.
module seg7_hex_decoder
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] glyph
);

    assign glyph = HEX_TABLE[nibble];

endmodule

// File: rtl/seg7_scan_ctrl.sv
// N-digit multiplexed seven-segment driver with double-buffered
// data, leading-zero suppression and 16-level PWM brightness.
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS = 8,
    parameter int DIV_WIDTH  = 17
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] data_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   blank_in,
    input  logic                    lzs_en,
    input  logic [3:0]              brightness,
    output logic [7:0]              SEG,
    output logic [NUM_DIGITS-1:0]   AN,
    output logic                    pending,
    output logic                    frame_tick
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

    logic [DIV_WIDTH-1:0]    slot_cnt_q, slot_cnt_d;
    logic [IDX_W-1:0]        digit_idx_q, digit_idx_d;
    logic [4*NUM_DIGITS-1:0] sh_data_q, sh_data_d;
    logic [NUM_DIGITS-1:0]   sh_dp_q, sh_dp_d;
    logic [NUM_DIGITS-1:0]   sh_blank_q, sh_blank_d;
    logic [4*NUM_DIGITS-1:0] act_data_q, act_data_d;
    logic [NUM_DIGITS-1:0]   act_dp_q, act_dp_d;
    logic [NUM_DIGITS-1:0]   act_blank_q, act_blank_d;
    logic                    pending_q, pending_d;
    logic [7:0]              seg_q, seg_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;

    logic                    slot_end;
    logic                    boundary;
    logic                    pwm_on;
    logic                    dark;
    logic                    run;
    logic [NUM_DIGITS-1:0]   sup;
    logic [3:0]              cur_nibble;
    logic [6:0]              glyph;

    assign slot_end   = &slot_cnt_q;
    assign boundary   = slot_end && (digit_idx_q == LAST_IDX);
    assign pwm_on     = slot_cnt_q[DIV_WIDTH-1 -: 4] <= brightness;
    assign cur_nibble = act_data_q[4*digit_idx_q +: 4];

    seg7_hex_decoder u_dec (
        .nibble (cur_nibble),
        .glyph  (glyph)
    );

    always_comb begin
        slot_cnt_d  = slot_cnt_q + 1'b1;
        digit_idx_d = digit_idx_q;
        if (slot_end) begin
            digit_idx_d = (digit_idx_q == LAST_IDX) ? '0
                                                    : digit_idx_q + 1'b1;
        end
    end

    // Shadow-to-active transfer happens before the new load lands,
    // so a load on the boundary keeps its data pending.
    always_comb begin
        sh_data_d   = sh_data_q;
        sh_dp_d     = sh_dp_q;
        sh_blank_d  = sh_blank_q;
        act_data_d  = act_data_q;
        act_dp_d    = act_dp_q;
        act_blank_d = act_blank_q;
        pending_d   = pending_q;
        if (boundary && pending_q) begin
            act_data_d  = sh_data_q;
            act_dp_d    = sh_dp_q;
            act_blank_d = sh_blank_q;
            pending_d   = 1'b0;
        end
        if (load) begin
            sh_data_d  = data_in;
            sh_dp_d    = dp_in;
            sh_blank_d = blank_in;
            pending_d  = 1'b1;
        end
    end

    always_comb begin
        run = 1'b1;
        sup = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            run = run & (act_data_q[4*i +: 4] == 4'h0) & ~act_dp_q[i];
            if (i > 0) sup[i] = run & lzs_en;
        end
    end

    always_comb begin
        dark  = act_blank_q[digit_idx_q] | sup[digit_idx_q];
        seg_d = SEG_OFF;
        an_d  = '1;
        if (!dark) begin
            seg_d[6:0]    = glyph;
            seg_d[DP_BIT] = ~act_dp_q[digit_idx_q];
            if (pwm_on) an_d[digit_idx_q] = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            slot_cnt_q  <= '0;
            digit_idx_q <= '0;
            sh_data_q   <= '0;
            sh_dp_q     <= '0;
            sh_blank_q  <= '1;
            act_data_q  <= '0;
            act_dp_q    <= '0;
            act_blank_q <= '1;
            pending_q   <= 1'b0;
            seg_q       <= SEG_OFF;
            an_q        <= '1;
        end else begin
            slot_cnt_q  <= slot_cnt_d;
            digit_idx_q <= digit_idx_d;
            sh_data_q   <= sh_data_d;
            sh_dp_q     <= sh_dp_d;
            sh_blank_q  <= sh_blank_d;
            act_data_q  <= act_data_d;
            act_dp_q    <= act_dp_d;
            act_blank_q <= act_blank_d;
            pending_q   <= pending_d;
            seg_q       <= seg_d;
            an_q        <= an_d;
        end
    end

    assign SEG        = seg_q;
    assign AN         = an_q;
    assign pending    = pending_q;
    assign frame_tick = boundary;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl, 4 digits, 16 clocks per slot.
module tb_seg7_scan_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        load = 1'b0;
    logic [15:0] data_in = '0;
    logic [3:0]  dp_in = '0;
    logic [3:0]  blank_in = '0;
    logic        lzs_en = 1'b0;
    logic [3:0]  brightness = 4'hF;
    logic [7:0]  SEG;
    logic [3:0]  AN;
    logic        pending;
    logic        frame_tick;

    int n_run = 0;
    int n_fail = 0;

    seg7_scan_ctrl #(.NUM_DIGITS(4), .DIV_WIDTH(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .data_in    (data_in),
        .dp_in      (dp_in),
        .blank_in   (blank_in),
        .lzs_en     (lzs_en),
        .brightness (brightness),
        .SEG        (SEG),
        .AN         (AN),
        .pending    (pending),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_load(input logic [15:0] d, input logic [3:0] dp,
                           input logic [3:0] bl);
        data_in  = d;
        dp_in    = dp;
        blank_in = bl;
        load     = 1'b1;
        @(negedge clk);
        load     = 1'b0;
    endtask

    task automatic wait_tick();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_tick && n < 200);
        chk("tick_seen", frame_tick, 1);
    endtask

    // Leaves the bench where outputs show digit 0, slot 0.
    task automatic sync_frame();
        wait_tick();
        repeat (2) @(negedge clk);
    endtask

    task automatic check_frame(input string tag, input logic [31:0] segs,
                               input logic [3:0] dark, input logic pend);
        logic [3:0] ea;
        logic [7:0] es;
        for (int d = 0; d < 4; d++) begin
            ea = 4'b0001 << d;
            ea = dark[d] ? 4'hF : ~ea;
            es = dark[d] ? 8'hFF : segs[8*d +: 8];
            chk($sformatf("%s_an%0d", tag, d), AN, ea);
            chk($sformatf("%s_seg%0d", tag, d), SEG, es);
            chk($sformatf("%s_pend%0d", tag, d), pending, pend);
            repeat (16) @(negedge clk);
        end
    endtask

    task automatic pwm_mask(input logic [3:0] an_exp,
                            output logic [15:0] mask);
        mask = '0;
        for (int s = 0; s < 16; s++) begin
            mask[s] = (AN == an_exp);
            @(negedge clk);
        end
    endtask

    logic [15:0] mask;

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_seg", SEG, 8'hFF);
        chk("rst_an", AN, 4'hF);
        chk("rst_pend", pending, 0);
        chk("rst_tick", frame_tick, 0);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("idle_seg", SEG, 8'hFF);
        chk("idle_an", AN, 4'hF);

        do_load(16'h12AF, 4'b0000, 4'b0000);
        chk("load_pend", pending, 1);
        sync_frame();
        check_frame("hex", {8'hF9, 8'hA4, 8'h88, 8'h8E}, 4'b0000, 0);

        lzs_en = 1'b1;
        do_load(16'h0005, 4'b0000, 4'b0000);
        sync_frame();
        check_frame("lzs", {8'hC0, 8'hC0, 8'hC0, 8'h92}, 4'b1110, 0);
        do_load(16'h0005, 4'b0100, 4'b0000);
        sync_frame();
        check_frame("lzsdp", {8'hC0, 8'h40, 8'hC0, 8'h92}, 4'b1000, 0);
        lzs_en = 1'b0;

        repeat (20) @(negedge clk);
        do_load(16'h1111, 4'b0000, 4'b0000);
        chk("mid1_pend", pending, 1);
        repeat (10) @(negedge clk);
        do_load(16'h2222, 4'b0000, 4'b0000);
        chk("mid2_pend", pending, 1);
        wait_tick();
        chk("mid_tick_pend", pending, 1);
        repeat (2) @(negedge clk);
        check_frame("latest", {4{8'hA4}}, 4'b0000, 0);

        do_load(16'h3333, 4'b0000, 4'b0000);
        wait_tick();
        data_in = 16'h4444;
        load    = 1'b1;
        chk("bnd_tick", frame_tick, 1);
        @(negedge clk);
        load    = 1'b0;
        chk("bnd_pend", pending, 1);
        @(negedge clk);
        check_frame("bnd", {4{8'hB0}}, 4'b0000, 1);
        chk("bnd_next_seg", SEG, 8'h99);
        chk("bnd_next_pend", pending, 0);

        brightness = 4'd3;
        sync_frame();
        pwm_mask(4'hE, mask);
        chk("pwm3_d0", mask, 16'h000F);
        pwm_mask(4'hD, mask);
        chk("pwm3_d1", mask, 16'h000F);
        brightness = 4'd15;
        sync_frame();
        pwm_mask(4'hE, mask);
        chk("pwm15_d0", mask, 16'hFFFF);

        do_load(16'h5555, 4'b0000, 4'b0000);
        repeat (5) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("arst_seg", SEG, 8'hFF);
        chk("arst_an", AN, 4'hF);
        chk("arst_pend", pending, 0);
        @(negedge clk);
        reset = 1'b0;
        sync_frame();
        check_frame("postrst", {4{8'h92}}, 4'b1111, 0);
        do_load(16'h6666, 4'b0000, 4'b0010);
        sync_frame();
        check_frame("blank", {4{8'h82}}, 4'b0010, 0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
